// File: rtl/alu_wb_stage.sv
// alu_wb_stage: execute->writeback pipeline stage behind the ALU.
// Buffers up to two ALU results (MAIN + SKID) in front of the register-file
// write port, owns the architectural Z flag and a retired-op counter.
module alu_wb_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_result,
  input  logic                  in_zero,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_wb_en,
  input  logic                  in_set_flags,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_result,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  out_wb_en,
  output logic                  z_flag,
  output logic [CNT_W-1:0]      retired_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0]     result;
    logic                  zero;
    logic [REG_ADDR_W-1:0] rd;
    logic                  wb_en;
    logic                  set_flags;
  } entry_t;

  state_t           state_q, state_d;
  entry_t           main_q, main_d;
  entry_t           skid_q, skid_d;
  logic             z_q, z_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  entry_t in_entry;
  logic   in_fire;
  logic   out_fire;

  // Handshake decodes come from registered state only, so in_ready never
  // depends combinationally on out_ready.
  always_comb begin
    in_entry.result    = in_result;
    in_entry.zero      = in_zero;
    in_entry.rd        = in_rd;
    in_entry.wb_en     = in_wb_en;
    in_entry.set_flags = in_set_flags;
    in_ready           = (state_q != TWO);
    out_valid          = (state_q != EMPTY);
    in_fire            = in_valid & in_ready;
    out_fire           = out_valid & out_ready;
  end

  // Next-state, buffer moves and retirement side effects (Z flag, counter).
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    z_d     = z_q;
    cnt_d   = cnt_q;

    // The write port has taken MAIN: retire it even if a flush is in progress.
    if (out_fire) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (main_q.set_flags) begin
        z_d = main_q.zero;
      end
    end

    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_d  = in_entry;
            state_d = ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_entry;
          end else if (in_fire) begin
            skid_d  = in_entry;
            state_d = TWO;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (out_fire) begin
            main_d  = skid_q;
            state_d = ONE;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  // State, buffers, flag and counter registers with async active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      z_q     <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      z_q     <= z_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_result    = main_q.result;
  assign out_rd        = main_q.rd;
  assign out_wb_en     = main_q.wb_en;
  assign z_flag        = z_q;
  assign retired_count = cnt_q;

endmodule

// File: tb/tb_alu_wb_stage.sv
// Directed testbench for alu_wb_stage: streaming, backpressure, flush,
// counter wrap (CNT_W=4) and asynchronous reset.
module tb_alu_wb_stage;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 4;
  localparam int CNT_W      = 4;

  logic                  clk;
  logic                  rst_n;
  logic                  flush;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_W-1:0]     in_result;
  logic                  in_zero;
  logic [REG_ADDR_W-1:0] in_rd;
  logic                  in_wb_en;
  logic                  in_set_flags;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_W-1:0]     out_result;
  logic [REG_ADDR_W-1:0] out_rd;
  logic                  out_wb_en;
  logic                  z_flag;
  logic [CNT_W-1:0]      retired_count;

  int checks;
  int failures;

  alu_wb_stage #(
    .DATA_W     (DATA_W),
    .REG_ADDR_W (REG_ADDR_W),
    .CNT_W      (CNT_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_result     (in_result),
    .in_zero       (in_zero),
    .in_rd         (in_rd),
    .in_wb_en      (in_wb_en),
    .in_set_flags  (in_set_flags),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_rd        (out_rd),
    .out_wb_en     (out_wb_en),
    .z_flag        (z_flag),
    .retired_count (retired_count)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drives every DUT input at once with blocking assignments.
  task automatic applyStimulus(input logic v, input logic [DATA_W-1:0] res,
                               input logic z, input logic [REG_ADDR_W-1:0] rd,
                               input logic wb, input logic sf,
                               input logic ordy, input logic fl);
    in_valid     = v;
    in_result    = res;
    in_zero      = z;
    in_rd        = rd;
    in_wb_en     = wb;
    in_set_flags = sf;
    out_ready    = ordy;
    flush        = fl;
  endtask

  // Single comparison point: counts and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Advance past the next rising edge so inputs change away from it.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset values
    #12;
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("rst_out_result", 64'(out_result), 64'd0);
    checkOutput("rst_out_rd", 64'(out_rd), 64'd0);
    checkOutput("rst_out_wb_en", 64'(out_wb_en), 64'd0);
    checkOutput("rst_z_flag", 64'(z_flag), 64'd0);
    checkOutput("rst_count", 64'(retired_count), 64'd0);
    #11 rst_n = 1'b1;
    nextCycle();

    // Streaming: A=5(z0), B=0(z1), C=FFFFFFFF(z0), out_ready=1
    applyStimulus(1'b1, 32'h5, 1'b0, 4'd1, 1'b1, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("st_in_ready0", 64'(in_ready), 64'd1);
    nextCycle();
    applyStimulus(1'b1, 32'h0, 1'b1, 4'd2, 1'b1, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("st_A_valid", 64'(out_valid), 64'd1);
    checkOutput("st_A_result", 64'(out_result), 64'h5);
    checkOutput("st_A_rd", 64'(out_rd), 64'd1);
    checkOutput("st_A_in_ready", 64'(in_ready), 64'd1);
    checkOutput("st_A_z", 64'(z_flag), 64'd0);
    nextCycle();
    applyStimulus(1'b1, 32'hFFFF_FFFF, 1'b0, 4'd3, 1'b1, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("st_B_result", 64'(out_result), 64'h0);
    checkOutput("st_B_rd", 64'(out_rd), 64'd2);
    checkOutput("st_B_in_ready", 64'(in_ready), 64'd1);
    checkOutput("st_B_z", 64'(z_flag), 64'd0);
    checkOutput("st_B_count", 64'(retired_count), 64'd1);
    nextCycle();
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("st_C_result", 64'(out_result), 64'hFFFF_FFFF);
    checkOutput("st_C_z", 64'(z_flag), 64'd1);
    checkOutput("st_C_count", 64'(retired_count), 64'd2);
    nextCycle();
    @(negedge clk);
    checkOutput("st_end_valid", 64'(out_valid), 64'd0);
    checkOutput("st_end_z", 64'(z_flag), 64'd0);
    checkOutput("st_end_count", 64'(retired_count), 64'd3);

    // Backpressure: D(z1,sf1), E(z0,sf1), F(z1,sf0,wb0) with out_ready=0
    nextCycle();
    applyStimulus(1'b1, 32'h11, 1'b1, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 32'h22, 1'b0, 4'd4, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("bp_D_result", 64'(out_result), 64'h11);
    nextCycle();
    applyStimulus(1'b1, 32'h33, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("bp_two_in_ready", 64'(in_ready), 64'd0);
    checkOutput("bp_two_result", 64'(out_result), 64'h11);
    nextCycle();
    @(negedge clk);
    checkOutput("bp_hold_in_ready", 64'(in_ready), 64'd0);
    checkOutput("bp_hold_result", 64'(out_result), 64'h11);
    checkOutput("bp_hold_rd", 64'(out_rd), 64'd3);
    checkOutput("bp_hold_count", 64'(retired_count), 64'd3);
    nextCycle();
    applyStimulus(1'b1, 32'h33, 1'b1, 4'd5, 1'b0, 1'b0, 1'b1, 1'b0);
    nextCycle();
    @(negedge clk);
    checkOutput("bp_E_valid", 64'(out_valid), 64'd1);
    checkOutput("bp_E_result", 64'(out_result), 64'h22);
    checkOutput("bp_E_rd", 64'(out_rd), 64'd4);
    checkOutput("bp_E_in_ready", 64'(in_ready), 64'd1);
    checkOutput("bp_E_z", 64'(z_flag), 64'd1);
    checkOutput("bp_E_count", 64'(retired_count), 64'd4);
    nextCycle();
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("bp_F_result", 64'(out_result), 64'h33);
    checkOutput("bp_F_wb_en", 64'(out_wb_en), 64'd0);
    checkOutput("bp_F_z", 64'(z_flag), 64'd0);
    checkOutput("bp_F_count", 64'(retired_count), 64'd5);
    nextCycle();
    @(negedge clk);
    checkOutput("bp_end_valid", 64'(out_valid), 64'd0);
    checkOutput("bp_end_z", 64'(z_flag), 64'd0);
    checkOutput("bp_end_count", 64'(retired_count), 64'd6);

    // Flush in TWO with z_flag=1: set Z first, then fill both slots
    applyStimulus(1'b1, 32'h0, 1'b1, 4'd6, 1'b1, 1'b1, 1'b1, 1'b0);
    nextCycle();
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 32'h44, 1'b0, 4'd7, 1'b1, 1'b1, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 32'h55, 1'b0, 4'd8, 1'b1, 1'b1, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 32'h66, 1'b0, 4'd9, 1'b1, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("fl_pre_in_ready", 64'(in_ready), 64'd0);
    checkOutput("fl_pre_z", 64'(z_flag), 64'd1);
    checkOutput("fl_pre_count", 64'(retired_count), 64'd7);
    nextCycle();
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("fl_valid", 64'(out_valid), 64'd0);
    checkOutput("fl_in_ready", 64'(in_ready), 64'd1);
    checkOutput("fl_z", 64'(z_flag), 64'd1);
    checkOutput("fl_count", 64'(retired_count), 64'd7);

    // Flush with a same-cycle retirement: J retires, K is dropped
    applyStimulus(1'b1, 32'h77, 1'b0, 4'd10, 1'b1, 1'b1, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 32'h88, 1'b1, 4'd11, 1'b1, 1'b1, 1'b1, 1'b1);
    nextCycle();
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("flr_valid", 64'(out_valid), 64'd0);
    checkOutput("flr_z", 64'(z_flag), 64'd0);
    checkOutput("flr_count", 64'(retired_count), 64'd8);
    nextCycle();
    @(negedge clk);
    checkOutput("flr_dropped_valid", 64'(out_valid), 64'd0);
    checkOutput("flr_dropped_count", 64'(retired_count), 64'd8);

    // Async reset while in TWO
    applyStimulus(1'b1, 32'h99, 1'b1, 4'd12, 1'b1, 1'b1, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 32'hAA, 1'b1, 4'd13, 1'b1, 1'b1, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("ar_pre_in_ready", 64'(in_ready), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("ar_valid", 64'(out_valid), 64'd0);
    checkOutput("ar_in_ready", 64'(in_ready), 64'd1);
    checkOutput("ar_result", 64'(out_result), 64'd0);
    checkOutput("ar_rd", 64'(out_rd), 64'd0);
    checkOutput("ar_count", 64'(retired_count), 64'd0);
    nextCycle();
    #3 rst_n = 1'b1;
    #1;
    checkOutput("ar_rel_in_ready", 64'(in_ready), 64'd1);
    checkOutput("ar_rel_valid", 64'(out_valid), 64'd0);

    // Counter wrap: 17 retirements on a 4-bit counter
    nextCycle();
    for (int i = 0; i < 17; i++) begin
      applyStimulus(1'b1, 32'hA0 + 32'(i), 1'b0, 4'(i), 1'b1, 1'b0, 1'b1, 1'b0);
      nextCycle();
      checkOutput("wr_result", 64'(out_result), 64'hA0 + 64'(i));
      if (i == 16) begin
        checkOutput("wr_count16", 64'(retired_count), 64'd0);
      end
    end
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    nextCycle();
    @(negedge clk);
    checkOutput("wr_valid", 64'(out_valid), 64'd0);
    checkOutput("wr_count", 64'(retired_count), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
